ps_alu_ctl: RTL and testbench

PS_ALU_CTL -- requirements
Module: ps_alu_ctl

---
 rtl/ps_alu_ctl_if.sv | 52 +++++
 rtl/ps_alu_ctl.sv | 196 +++++++++++++++++++
 tb/tb_ps_alu_ctl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_alu_ctl_if.sv
// Instruction, ALU and crossbar signal bundle for the ps_alu_ctl sequencer.
// The master side is the instruction/ALU environment; the controller is the slave.
interface ps_alu_ctl_if #(
  parameter int ADDR_WIDTH = 4
);
  localparam int IW = 12 + 3 * ADDR_WIDTH;

  logic                  ps_instr_valid;
  logic                  ps_instr_ready;
  logic [IW-1:0]         ps_instr;

  logic                  ps_alu_en;
  logic                  ps_alu_log;
  logic                  ps_alu_sat;
  logic [1:0]            ps_alu_hc;
  logic [2:0]            ps_alu_sc;

  logic                  alu_ps_az;
  logic                  alu_ps_an;
  logic                  alu_ps_ac;
  logic                  alu_ps_av;

  logic [ADDR_WIDTH-1:0] ps_xb_rdx;
  logic [ADDR_WIDTH-1:0] ps_xb_rdy;
  logic [ADDR_WIDTH-1:0] ps_xb_wa;
  logic                  ps_xb_we;

  logic [3:0]            ps_astat;
  logic                  ps_stky_av;
  logic                  ps_stky_clr;
  logic                  ps_illegal;

  modport master (
    output ps_instr_valid, ps_instr,
    output alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av,
    output ps_stky_clr,
    input  ps_instr_ready,
    input  ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_hc, ps_alu_sc,
    input  ps_xb_rdx, ps_xb_rdy, ps_xb_wa, ps_xb_we,
    input  ps_astat, ps_stky_av, ps_illegal
  );

  modport slave (
    input  ps_instr_valid, ps_instr,
    input  alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av,
    input  ps_stky_clr,
    output ps_instr_ready,
    output ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_hc, ps_alu_sc,
    output ps_xb_rdx, ps_xb_rdy, ps_xb_wa, ps_xb_we,
    output ps_astat, ps_stky_av, ps_illegal
  );
endinterface

// File: rtl/ps_alu_ctl.sv
// Two-cycle ALU instruction sequencer: decode/condition/issue, then write-back and flag capture.
// Optional PS_ALU_SAT_EN adds the ps_mode_alusat input that drives ps_alu_sat.
module ps_alu_ctl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef PS_ALU_SAT_EN
  input  logic ps_mode_alusat,
`endif
  ps_alu_ctl_if.slave bus
);
  localparam int IW = 12 + 3 * ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            astat_q, astat_d;
  logic                  stky_q, stky_d;
  logic [1:0]            hc_q, hc_d;
  logic [2:0]            sc_q, sc_d;
  logic                  log_q, log_d;
  logic                  illegal_q, illegal_d;
  logic [ADDR_WIDTH-1:0] rn_q, rn_d;
  logic [ADDR_WIDTH-1:0] rdx_q, rdx_d;
  logic [ADDR_WIDTH-1:0] rdy_q, rdy_d;
  logic                  cmp_q, cmp_d;

  logic [1:0]            f_cls;
  logic [1:0]            f_hc;
  logic [2:0]            f_sc;
  logic                  f_log;
  logic [3:0]            f_cond;
  logic [ADDR_WIDTH-1:0] f_rn;
  logic [ADDR_WIDTH-1:0] f_rx;
  logic [ADDR_WIDTH-1:0] f_ry;

  logic                  ready;
  logic                  accept;
  logic                  legal;
  logic                  issue;
  logic                  f_cmp;

  function automatic logic op_legal(input logic [1:0] cls, input logic lg,
                                    input logic [1:0] hc, input logic [2:0] sc);
    logic ok;
    ok = 1'b0;
    if (cls == 2'b01) begin
      if (lg) begin
        case ({hc, sc})
          5'b00_000, 5'b00_001, 5'b00_010,
          5'b10_000, 5'b10_001, 5'b11_000: ok = 1'b1;
          default:                         ok = 1'b0;
        endcase
      end else begin
        case ({hc, sc})
          5'b00_000, 5'b00_001, 5'b00_010, 5'b00_011, 5'b00_101,
          5'b01_001, 5'b01_011, 5'b10_001, 5'b11_001: ok = 1'b1;
          default:                                    ok = 1'b0;
        endcase
      end
    end
    return ok;
  endfunction

  // Status layout is {AV, AC, AN, AZ}.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] st);
    logic ok;
    case (cond)
      4'd0:    ok = st[0];
      4'd1:    ok = ~st[0];
      4'd2:    ok = st[1];
      4'd3:    ok = ~st[1];
      4'd4:    ok = st[2];
      4'd5:    ok = ~st[2];
      4'd6:    ok = st[3];
      4'd7:    ok = ~st[3];
      4'd15:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign f_cls  = bus.ps_instr[IW-1 -: 2];
  assign f_hc   = bus.ps_instr[IW-3 -: 2];
  assign f_sc   = bus.ps_instr[IW-5 -: 3];
  assign f_log  = bus.ps_instr[IW-8];
  assign f_cond = bus.ps_instr[IW-9 -: 4];
  assign f_rn   = bus.ps_instr[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign f_rx   = bus.ps_instr[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign f_ry   = bus.ps_instr[ADDR_WIDTH-1:0];

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign ready  = (state_q == IDLE) && !reset;
  assign accept = bus.ps_instr_valid && ready;
  assign legal  = op_legal(f_cls, f_log, f_hc, f_sc);
  assign issue  = accept && legal && cond_ok(f_cond, astat_q);
  assign f_cmp  = !f_log && (f_hc == 2'b00) && (f_sc == 3'b101);

  always_comb begin
    state_d   = state_q;
    astat_d   = astat_q;
    hc_d      = hc_q;
    sc_d      = sc_q;
    log_d     = log_q;
    illegal_d = 1'b0;
    rn_d      = rn_q;
    rdx_d     = rdx_q;
    rdy_d     = rdy_q;
    cmp_d     = cmp_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = EXEC;
          hc_d    = f_hc;
          sc_d    = f_sc;
          log_d   = f_log;
          rn_d    = f_rn;
          rdx_d   = f_rx;
          rdy_d   = f_ry;
          cmp_d   = f_cmp;
        end else if (accept && !legal) begin
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        state_d = IDLE;
        astat_d = {bus.alu_ps_av, bus.alu_ps_ac, bus.alu_ps_an, bus.alu_ps_az};
      end
      default: state_d = IDLE;
    endcase
    // A new overflow beats a simultaneous clear.
    stky_d = ((state_q == EXEC) && bus.alu_ps_av) || (stky_q && !bus.ps_stky_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      astat_q   <= 4'b0000;
      stky_q    <= 1'b0;
      hc_q      <= 2'b00;
      sc_q      <= 3'b000;
      log_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      astat_q   <= astat_d;
      stky_q    <= stky_d;
      hc_q      <= hc_d;
      sc_q      <= sc_d;
      log_q     <= log_d;
      illegal_q <= illegal_d;
    end
  end

  // Operand/address capture only matters while EXEC is active, so it carries no reset.
  always_ff @(posedge clk) begin
    rn_q  <= rn_d;
    rdx_q <= rdx_d;
    rdy_q <= rdy_d;
    cmp_q <= cmp_d;
  end

`ifdef PS_ALU_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = issue && ps_mode_alusat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign bus.ps_alu_sat = issue ? ps_mode_alusat : sat_q;
`else
  assign bus.ps_alu_sat = 1'b0;
`endif

  assign bus.ps_instr_ready = ready;
  assign bus.ps_alu_en      = issue;
  assign bus.ps_alu_hc      = issue ? f_hc  : hc_q;
  assign bus.ps_alu_sc      = issue ? f_sc  : sc_q;
  assign bus.ps_alu_log     = issue ? f_log : log_q;
  assign bus.ps_xb_rdx      = issue ? f_rx  : rdx_q;
  assign bus.ps_xb_rdy      = issue ? f_ry  : rdy_q;
  assign bus.ps_xb_wa       = rn_q;
  assign bus.ps_xb_we       = (state_q == EXEC) && !cmp_q && !reset;
  assign bus.ps_astat       = astat_q;
  assign bus.ps_stky_av     = stky_q;
  assign bus.ps_illegal     = illegal_q;
endmodule

// File: tb/tb_ps_alu_ctl.sv
// Directed bench for ps_alu_ctl: write-back records and flag results go through a scoreboard queue.
module tb_ps_alu_ctl;
  localparam int AW = 4;
  localparam int IW = 12 + 3 * AW;
`ifdef PS_ALU_SAT_EN
  localparam logic SAT_ON = 1'b1;
  logic mode;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [3:0]    astat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  ps_alu_ctl_if #(.ADDR_WIDTH(AW)) bus ();

  ps_alu_ctl #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef PS_ALU_SAT_EN
    .ps_mode_alusat (mode),
`endif
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] mk(input logic [1:0] cls, input logic [1:0] hc,
                                       input logic [2:0] sc, input logic lg, input logic [3:0] cond,
                                       input logic [3:0] rn, input logic [3:0] rx, input logic [3:0] ry);
    return {cls, hc, sc, lg, cond, rn, rx, ry};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {bus.alu_ps_av, bus.alu_ps_ac, bus.alu_ps_an, bus.alu_ps_az} = f;
  endtask

  // Full issue: accept cycle, EXEC cycle, then the cycle after the exit edge.
  task automatic issue_op(input string tag, input logic [IW-1:0] instr,
                          input logic [3:0] rdx, input logic [3:0] rdy,
                          input logic [1:0] hc, input logic [2:0] sc, input logic lg,
                          input logic we, input logic [3:0] wa,
                          input logic [3:0] flags, input logic clr, input logic [3:0] astat);
    exp_t e;
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = instr;
    sb.push_back('{we: we, wa: wa, astat: astat});
    #1;
    chk({tag, ".ready"}, bus.ps_instr_ready, 1);
    chk({tag, ".en"},    bus.ps_alu_en, 1);
    chk({tag, ".rdx"},   bus.ps_xb_rdx, rdx);
    chk({tag, ".rdy"},   bus.ps_xb_rdy, rdy);
    chk({tag, ".op"},    {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc}, {lg, hc, sc});
    tick();
    bus.ps_instr_valid = 1'b0;
    set_flags(flags);
    bus.ps_stky_clr = clr;
    #1;
    e = sb.pop_front();
    chk({tag, ".exec_ready"}, bus.ps_instr_ready, 0);
    chk({tag, ".exec_en"},    bus.ps_alu_en, 0);
    chk({tag, ".exec_hold"},  {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc}, {lg, hc, sc});
    chk({tag, ".we"},         bus.ps_xb_we, e.we);
    if (e.we) chk({tag, ".wa"}, bus.ps_xb_wa, e.wa);
    tick();
    set_flags(4'b0000);
    bus.ps_stky_clr = 1'b0;
    chk({tag, ".astat"}, bus.ps_astat, e.astat);
    chk({tag, ".post_we"}, bus.ps_xb_we, 0);
  endtask

  initial begin
    exp_t e;
    reset              = 1'b1;
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = mk(2'b01, 2'b00, 3'b000, 1'b0, 4'd15, 4'd3, 4'd1, 4'd2);
    bus.ps_stky_clr    = 1'b0;
    set_flags(4'b0000);
`ifdef PS_ALU_SAT_EN
    mode = 1'b0;
`endif
    #12;
    chk("rst.ready",   bus.ps_instr_ready, 0);
    chk("rst.en",      bus.ps_alu_en, 0);
    chk("rst.astat",   bus.ps_astat, 0);
    chk("rst.stky",    bus.ps_stky_av, 0);
    chk("rst.op",      {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc, bus.ps_alu_sat}, 0);
    chk("rst.illegal", bus.ps_illegal, 0);
    chk("rst.we",      bus.ps_xb_we, 0);
    bus.ps_instr_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("idle.ready", bus.ps_instr_ready, 1);

    // Add with TRUE condition; ALU reports zero.
    issue_op("add", mk(2'b01, 2'b00, 3'b000, 1'b0, 4'd15, 4'd3, 4'd1, 4'd2),
             4'd1, 4'd2, 2'b00, 3'b000, 1'b0, 1'b1, 4'd3, 4'b0001, 1'b0, 4'b0001);

    // Compare: no write-back, flags still captured.
    issue_op("cmp", mk(2'b01, 2'b00, 3'b101, 1'b0, 4'd15, 4'd5, 4'd6, 4'd7),
             4'd6, 4'd7, 2'b00, 3'b101, 1'b0, 1'b0, 4'd5, 4'b0001, 1'b0, 4'b0001);

    // NE with AZ set: consumed silently, op outputs keep the compare code.
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = mk(2'b01, 2'b00, 3'b000, 1'b0, 4'd1, 4'd3, 4'd1, 4'd2);
    #1;
    chk("ne.ready", bus.ps_instr_ready, 1);
    chk("ne.en",    bus.ps_alu_en, 0);
    chk("ne.hold",  {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc}, {1'b0, 2'b00, 3'b101});
    tick();
    bus.ps_instr_valid = 1'b0;
    #1;
    chk("ne.we",      bus.ps_xb_we, 0);
    chk("ne.ready2",  bus.ps_instr_ready, 1);
    chk("ne.illegal", bus.ps_illegal, 0);
    chk("ne.astat",   bus.ps_astat, 4'b0001);

    // Illegal logic op 10/010.
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = mk(2'b01, 2'b10, 3'b010, 1'b1, 4'd15, 4'd8, 4'd8, 4'd8);
    #1;
    chk("ill.en", bus.ps_alu_en, 0);
    tick();
    bus.ps_instr_valid = 1'b0;
    #1;
    chk("ill.pulse", bus.ps_illegal, 1);
    chk("ill.ready", bus.ps_instr_ready, 1);
    chk("ill.astat", bus.ps_astat, 4'b0001);
    chk("ill.we",    bus.ps_xb_we, 0);
    tick();
    chk("ill.end", bus.ps_illegal, 0);

    // Logic op on EQ; overflow arrives together with a sticky clear.
    issue_op("and", mk(2'b01, 2'b10, 3'b001, 1'b1, 4'd0, 4'd9, 4'd10, 4'd11),
             4'd10, 4'd11, 2'b10, 3'b001, 1'b1, 1'b1, 4'd9, 4'b1100, 1'b1, 4'b1100);
    chk("and.stky", bus.ps_stky_av, 1);

    // Back-to-back issue conditioned on the AV just written.
    issue_op("b2b", mk(2'b01, 2'b00, 3'b001, 1'b0, 4'd6, 4'd4, 4'd2, 4'd3),
             4'd2, 4'd3, 2'b00, 3'b001, 1'b0, 1'b1, 4'd4, 4'b0000, 1'b0, 4'b0000);
    chk("b2b.stky", bus.ps_stky_av, 1);

    bus.ps_stky_clr = 1'b1;
    tick();
    bus.ps_stky_clr = 1'b0;
    chk("clr.stky",  bus.ps_stky_av, 0);
    chk("clr.astat", bus.ps_astat, 4'b0000);

    // LT with AN clear is false; class 00 is illegal regardless of condition.
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = mk(2'b01, 2'b11, 3'b001, 1'b0, 4'd2, 4'd1, 4'd1, 4'd1);
    #1;
    chk("lt.en", bus.ps_alu_en, 0);
    tick();
    bus.ps_instr = mk(2'b00, 2'b00, 3'b000, 1'b0, 4'd15, 4'd1, 4'd1, 4'd1);
    #1;
    chk("lt.illegal", bus.ps_illegal, 0);
    chk("cls0.en",    bus.ps_alu_en, 0);
    tick();
    bus.ps_instr_valid = 1'b0;
    #1;
    chk("cls0.illegal", bus.ps_illegal, 1);
    tick();

    // Reset during EXEC drops the write and the pending flags.
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = mk(2'b01, 2'b01, 3'b011, 1'b0, 4'd15, 4'd7, 4'd1, 4'd1);
    sb.push_back('{we: 1'b1, wa: 4'd7, astat: 4'b0000});
    #1;
    chk("rx.en", bus.ps_alu_en, 1);
    tick();
    bus.ps_instr_valid = 1'b0;
    set_flags(4'b1111);
    #1;
    e = sb.pop_front();
    chk("rx.we", bus.ps_xb_we, e.we);
    chk("rx.wa", bus.ps_xb_wa, e.wa);
    reset = 1'b1;
    #1;
    chk("rx.we_drop", bus.ps_xb_we, 0);
    chk("rx.ready",   bus.ps_instr_ready, 0);
    chk("rx.astat",   bus.ps_astat, e.astat);
    chk("rx.op",      {bus.ps_alu_hc, bus.ps_alu_sc}, 0);
    tick();
    chk("rx.stky", bus.ps_stky_av, 0);
    set_flags(4'b0000);
    reset = 1'b0;
    #1;
    chk("rx.idle", bus.ps_instr_ready, 1);

    // Saturation mode sampled at accept and held through EXEC.
`ifdef PS_ALU_SAT_EN
    mode = 1'b1;
`endif
    bus.ps_instr_valid = 1'b1;
    bus.ps_instr       = mk(2'b01, 2'b00, 3'b000, 1'b0, 4'd15, 4'd1, 4'd2, 4'd3);
    #1;
    chk("sat.acc", bus.ps_alu_sat, SAT_ON);
    tick();
    bus.ps_instr_valid = 1'b0;
`ifdef PS_ALU_SAT_EN
    mode = 1'b0;
`endif
    #1;
    chk("sat.exec", bus.ps_alu_sat, SAT_ON);
    tick();
    chk("sat.after", bus.ps_alu_sat, 0);
    chk("sb.empty",  sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
